dmem_access_unit: RTL and testbench



---
 rtl/dmem_access_unit_pkg.sv | 33 +++
 rtl/dmem_access_unit_load_extend.sv | 32 +++
 rtl/dmem_access_unit.sv | 173 +++++++++++++++++
 tb/tb_dmem_access_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_unit_pkg.sv
// Shared types and constants for the data-memory access controller:
// FSM state encoding, func3 access codes and the request legality check.
package dmem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Size/alignment legality; unsigned variants exist only for loads.
    function automatic logic f_access_legal(input logic [2:0] func3,
                                            input logic [1:0] addr_lo,
                                            input logic       is_store);
        logic ok;
        case (func3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~addr_lo[0];
            F3_W:        ok = (addr_lo == 2'b00);
            default:     ok = 1'b0;
        endcase
        if (is_store && func3[2])
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/dmem_access_unit_load_extend.sv
// load_extend: selects the addressed byte/half lane of a memory read word
// and sign- or zero-extends it according to func3.
module load_extend
    import dmem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_addr_lo,
    input  logic [2:0]        i_func3,
    output logic [DATA_W-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select followed by extension.
    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
        o_data = '0;
        case (i_func3)
            F3_B:    o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            F3_BU:   o_data = {{(DATA_W-8){1'b0}}, w_byte};
            F3_H:    o_data = {{(DATA_W-16){w_half[15]}}, w_half};
            F3_HU:   o_data = {{(DATA_W-16){1'b0}}, w_half};
            F3_W:    o_data = i_rdata;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage data-memory controller. Turns MemRead/MemWrite
// into a word-organised req/ready access, stalls the pipeline while the access
// is in flight and returns extended load data in ReadData.
// Optional feature: define MEM_TIMEOUT_EN to abort a REQ that sees no m_ready
// within TIMEOUT_CYC cycles.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     ReadData,
    output logic                  mem_stall,
    output logic                  acc_err,
    output logic                  m_req,
    output logic                  m_we,
    output logic [DM_ADDRESS-3:0] m_addr,
    output logic [3:0]            m_be,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic                  m_ready
);

    dmem_state_t           r_state;
    dmem_state_t           w_next;

    logic [DM_ADDRESS-3:0] r_word_addr;
    logic [1:0]            r_addr_lo;
    logic [2:0]            r_func3;
    logic                  r_we;
    logic [3:0]            r_be;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_err;
    logic [DATA_W-1:0]     r_rdata;

    logic                  w_access;
    logic                  w_legal;
    logic [3:0]            w_be;
    logic [DATA_W-1:0]     w_lane_data;
    logic [DATA_W-1:0]     w_ext;
    logic                  w_timeout;

    assign w_access = MemRead | MemWrite;
    // MemWrite alone decides direction, so Read+Write is a store.
    assign w_legal  = f_access_legal(func3, addr[1:0], MemWrite);

`ifdef MEM_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMO_W-1:0] r_tmo_cnt;

    // REQ cycle counter; zero on every entry into REQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_tmo_cnt <= '0;
        else if (r_state == REQ)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        else
            r_tmo_cnt <= '0;
    end

    assign w_timeout = (r_state == REQ) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Byte enables and lane-replicated store data for the requested size.
    always_comb begin
        w_be        = '0;
        w_lane_data = '0;
        case (func3[1:0])
            2'b00: begin
                w_be        = 4'b0001 << addr[1:0];
                w_lane_data = {4{wr_data[7:0]}};
            end
            2'b01: begin
                w_be        = addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{wr_data[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_lane_data = wr_data;
            end
        endcase
    end

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .i_rdata   (m_rdata),
        .i_addr_lo (r_addr_lo),
        .i_func3   (r_func3),
        .o_data    (w_ext)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next state, stall and request strobe.
    always_comb begin
        w_next    = r_state;
        mem_stall = 1'b0;
        m_req     = 1'b0;
        case (r_state)
            IDLE: begin
                mem_stall = w_access;
                if (w_access)
                    w_next = w_legal ? REQ : DONE;
            end
            REQ: begin
                mem_stall = 1'b1;
                m_req     = 1'b1;
                if (m_ready || w_timeout)
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request latches captured on acceptance in IDLE, plus the error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word_addr <= '0;
            r_addr_lo   <= '0;
            r_func3     <= '0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
        end else if (r_state == IDLE && w_access) begin
            r_word_addr <= addr[DM_ADDRESS-1:2];
            r_addr_lo   <= addr[1:0];
            r_func3     <= func3;
            r_we        <= MemWrite;
            r_be        <= w_be;
            r_wdata     <= MemWrite ? w_lane_data : '0;
            r_err       <= ~w_legal;
        end else if (r_state == REQ && !m_ready && w_timeout) begin
            r_err       <= 1'b1;
        end
    end

    // ReadData: extended word on load completion, zero on store/error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_rdata <= '0;
        else if (r_state == IDLE && w_access && !w_legal)
            r_rdata <= '0;
        else if (r_state == REQ && m_ready)
            r_rdata <= r_we ? '0 : w_ext;
        else if (r_state == REQ && w_timeout)
            r_rdata <= '0;
    end

    assign ReadData = r_rdata;
    assign acc_err  = (r_state == DONE) && r_err;
    assign m_we     = r_we && (r_state == REQ);
    assign m_addr   = r_word_addr;
    assign m_be     = r_be;
    assign m_wdata  = r_wdata;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: the driver pushes the expected
// memory-side request and completion per access; a negedge monitor checks
// the request while m_req is high and the completion when stall falls.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [2:0]  func3 = '0;
    logic [31:0] ReadData;
    logic        mem_stall;
    logic        acc_err;
    logic        m_req;
    logic        m_we;
    logic [6:0]  m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ready = 1'b0;

    dmem_access_unit #(.DM_ADDRESS(9), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr(addr), .wr_data(wr_data), .func3(func3), .ReadData(ReadData),
        .mem_stall(mem_stall), .acc_err(acc_err), .m_req(m_req), .m_we(m_we),
        .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        has_req;
        logic        we;
        logic [6:0]  maddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int unsigned stalls;
    } exp_t;

    exp_t q[$];
    int unsigned checks = 0;
    int unsigned failures = 0;
    bit          mon_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: request fields while m_req is high, completion when stall drops.
    initial begin : monitor
        bit          in_acc = 1'b0;
        int unsigned nst = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!mon_en || !reset) begin
                in_acc = 1'b0;
                nst    = 0;
            end else begin
                if (m_req) begin
                    if (q.size() == 0) begin
                        chk("req_unexpected", 32'(m_req), 32'd0);
                    end else begin
                        e = q[0];
                        chk("req_allowed", 32'(e.has_req), 32'd1);
                        chk("m_we",    32'(m_we),   32'(e.we));
                        chk("m_addr",  32'(m_addr), 32'(e.maddr));
                        chk("m_be",    32'(m_be),   32'(e.be));
                        chk("m_wdata", m_wdata,     e.wdata);
                    end
                end
                if (mem_stall) begin
                    in_acc = 1'b1;
                    nst++;
                end else if (in_acc) begin
                    in_acc = 1'b0;
                    if (q.size() == 0) begin
                        chk("done_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("ReadData",     ReadData,     e.rdata);
                        chk("acc_err",      32'(acc_err), 32'(e.err));
                        chk("stall_cycles", nst,          e.stalls);
                    end
                    nst = 0;
                end else begin
                    chk("acc_err_idle", 32'(acc_err), 32'd0);
                end
            end
        end
    end

    // Issue one access; m_ready is raised after dly REQ cycles.
    task automatic do_access(input logic rd, input logic wr, input logic [8:0] a,
                             input logic [31:0] wd, input logic [2:0] f3,
                             input int unsigned dly, input logic [31:0] rdv,
                             input logic hreq, input logic [3:0] be,
                             input logic [31:0] ewd, input logic err,
                             input logic [31:0] erd, input int unsigned est);
        exp_t        e;
        int unsigned n;
        bit          done;
        e.has_req = hreq;
        e.we      = wr;
        e.maddr   = a[8:2];
        e.be      = be;
        e.wdata   = ewd;
        e.err     = err;
        e.rdata   = erd;
        e.stalls  = est;
        q.push_back(e);
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; addr = a; wr_data = wd; func3 = f3; m_rdata = rdv;
        n = 0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk); #1;
            if (!mem_stall) begin
                done = 1'b1;
            end else begin
                m_ready = (n == dly);
                n++;
            end
        end
        MemRead = 1'b0; MemWrite = 1'b0; m_ready = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL access_timeout: no completion within 100 cycles, addr %h expected done", a);
        end
    endtask

    initial begin : stim
        #12;
        chk("rst_ReadData", ReadData,      32'd0);
        chk("rst_acc_err",  32'(acc_err),  32'd0);
        chk("rst_m_req",    32'(m_req),    32'd0);
        chk("rst_m_we",     32'(m_we),     32'd0);
        chk("rst_m_addr",   32'(m_addr),   32'd0);
        chk("rst_m_be",     32'(m_be),     32'd0);
        chk("rst_m_wdata",  m_wdata,       32'd0);
        chk("rst_stall",    32'(mem_stall), 32'd0);
        #3 reset = 1'b1;

        //        rd wr addr    wdata         f3    dly rdata         req be     ewdata        err erd           stalls
        do_access(1, 0, 9'h010, 32'h0,        3'b010, 0, 32'hDEADBEEF, 1, 4'hF, 32'h0,        0, 32'hDEADBEEF, 2); // lw
        do_access(1, 0, 9'h013, 32'h0,        3'b000, 0, 32'h80FF0000, 1, 4'h8, 32'h0,        0, 32'hFFFFFF80, 2); // lb
        do_access(1, 0, 9'h013, 32'h0,        3'b100, 0, 32'h80FF0000, 1, 4'h8, 32'h0,        0, 32'h00000080, 2); // lbu
        do_access(0, 1, 9'h006, 32'h0000ABCD, 3'b001, 3, 32'h0,        1, 4'hC, 32'hABCDABCD, 0, 32'h0,        5); // sh
        do_access(1, 0, 9'h002, 32'h0,        3'b010, 0, 32'h0,        0, 4'h0, 32'h0,        1, 32'h0,        1); // lw misaligned
        do_access(1, 0, 9'h012, 32'h0,        3'b001, 1, 32'h80011234, 1, 4'hC, 32'h0,        0, 32'hFFFF8001, 3); // lh
        do_access(0, 1, 9'h005, 32'h123456A5, 3'b000, 0, 32'h0,        1, 4'h2, 32'hA5A5A5A5, 0, 32'h0,        2); // sb
        do_access(0, 1, 9'h1FC, 32'hCAFEF00D, 3'b010, 0, 32'h0,        1, 4'hF, 32'hCAFEF00D, 0, 32'h0,        2); // sw top
        do_access(1, 1, 9'h008, 32'h01020304, 3'b010, 0, 32'hFFFFFFFF, 1, 4'hF, 32'h01020304, 0, 32'h0,        2); // rd+wr = store
        do_access(1, 0, 9'h000, 32'h0,        3'b011, 0, 32'h0,        0, 4'h0, 32'h0,        1, 32'h0,        1); // f3 011
        do_access(0, 1, 9'h001, 32'h0,        3'b001, 0, 32'h0,        0, 4'h0, 32'h0,        1, 32'h0,        1); // sh odd
        do_access(0, 1, 9'h000, 32'h0,        3'b100, 0, 32'h0,        0, 4'h0, 32'h0,        1, 32'h0,        1); // store f3[2]
        do_access(1, 0, 9'h003, 32'h0,        3'b101, 0, 32'h0,        0, 4'h0, 32'h0,        1, 32'h0,        1); // lhu odd
        do_access(1, 0, 9'h010, 32'h0,        3'b101, 2, 32'h8001F234, 1, 4'h3, 32'h0,        0, 32'h0000F234, 4); // lhu
`ifdef MEM_TIMEOUT_EN
        do_access(1, 0, 9'h040, 32'h0,        3'b010, 1000, 32'h1234,  1, 4'hF, 32'h0,        1, 32'h0,       17); // timeout
        do_access(1, 0, 9'h010, 32'h0,        3'b101, 0, 32'h8001F234, 1, 4'h3, 32'h0,        0, 32'h0000F234, 2); // reload
`endif

        // m_ready outside REQ has no effect.
        @(posedge clk); #1; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ready_req",   32'(m_req),     32'd0);
        chk("idle_ready_stall", 32'(mem_stall), 32'd0);
        chk("idle_ready_rdata", ReadData,       32'h0000F234);
        m_ready = 1'b0;

        // Reset asserted while an access waits in REQ.
        mon_en = 1'b0;
        @(posedge clk); #1;
        MemRead = 1'b1; addr = 9'h020; func3 = 3'b010; m_rdata = 32'h55AA55AA;
        @(posedge clk); #1;
        chk("midreq_m_req_before", 32'(m_req), 32'd1);
        @(posedge clk); #3;
        reset = 1'b0; MemRead = 1'b0;
        #1;
        chk("midreq_m_req",    32'(m_req),     32'd0);
        chk("midreq_stall",    32'(mem_stall), 32'd0);
        chk("midreq_ReadData", ReadData,       32'd0);
        chk("midreq_m_be",     32'(m_be),      32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        do_access(1, 0, 9'h024, 32'h0, 3'b010, 1, 32'h13579BDF, 1, 4'hF, 32'h0, 0, 32'h13579BDF, 3);

        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
